block_data_memory: RTL and testbench

Main-memory responder on the data path, sitting behind the data cache on the block-transfer interface. Stores 64 blocks of 4 bytes (256 bytes) and serves one 32-bit block read or write per request. Each access is held off with a busywait handshake for a fixed multi-cycle latency. It is the responding end of the cache's miss/write-back port: the cache drives READ/WRITE/ADDRESS/WRITEDATA, and this block returns READDATA/BUSYWAIT.

---
 rtl/block_data_memory.sv | 141 ++++++++++++++
 tb/tb_block_data_memory.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//
// Main-memory responder behind the data cache. Holds 64 blocks of 4 bytes
// (256 x 8-bit) and serves one 32-bit block read or write per request, holding
// the requester off with BUSYWAIT for a fixed LATENCY posedges.
//
// Parameters
//   LATENCY    posedges from request acceptance to access completion (2..15)
//
// Ports
//   CLK        in   1   system clock, all state changes on posedge
//   RESET      in   1   synchronous active-high reset; clears memory and READDATA
//   READ       in   1   block read request, held until BUSYWAIT is seen low
//   WRITE      in   1   block write request, same hold rule as READ
//   ADDRESS    in   6   block address (byte address bits [7:2])
//   WRITEDATA  in  32   block to write, byte 0 in [7:0] .. byte 3 in [31:24]
//   READDATA   out 32   last block read, same byte order as WRITEDATA
//   BUSYWAIT   out  1   high while a request is pending or in progress
// -----------------------------------------------------------------------------
module block_data_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [5:0]  ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Counter value seen on the completing posedge (E0 + LATENCY).
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;
  logic [31:0] rd_block;

  logic [7:0]  mem_q [256];

  // Gather the four bytes of the latched block; byte 4A+k lands on [8k+7:8k].
  always_comb begin
    rd_block = '0;
    for (int k = 0; k < 4; k++) begin
      rd_block[8*k +: 8] = mem_q[{addr_q, 2'(k)}];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (READ || WRITE) begin
          state_d = BUSY;
          cnt_d   = '0;
          // READ and WRITE together resolve to a write.
          op_wr_d = WRITE;
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = rd_block;
          end
        end
      end
      // One dead cycle while the requester drops READ/WRITE.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array is cleared on reset because reset must leave the
  // memory all zero; this forces flop-based storage rather than a RAM macro.
  // Reset also takes priority over a completing write, so an aborted write
  // never reaches the array.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[{addr_q, 2'(k)}] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign READDATA = rdata_q;
  // Combinational so it rises in the same cycle a request appears.
  assign BUSYWAIT = ((state_q == IDLE) && (READ || WRITE)) || (state_q == BUSY);

endmodule

// File: tb/tb_block_data_memory.sv
// -----------------------------------------------------------------------------
// tb_block_data_memory
//
// Self-checking bench for block_data_memory with LATENCY = 5. A table of
// directed access records is applied in a loop, followed by hand-written
// sequences for the handshake timing, mid-access input changes and reset
// during a write. Inputs change #1 after a posedge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_block_data_memory;

  localparam int unsigned LAT = 5;
  // Posedges from request assertion until BUSYWAIT is seen low:
  // the accepting edge E0 plus LAT more.
  localparam int EXP_EDGES = LAT + 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [5:0]  ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;

  int n_total  = 0;
  int n_passed = 0;

  block_data_memory #(.LATENCY(LAT)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full handshake: raise the request, count posedges until BUSYWAIT drops
  // (bounded), release the request in DONE, then step back into IDLE.
  task automatic access(input logic rd, input logic wr, input logic [5:0] a,
                        input logic [31:0] d, output logic busy_at_req,
                        output int edges);
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = a;
    WRITEDATA = d;
    #1;
    busy_at_req = BUSYWAIT;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (BUSYWAIT && edges < 30);
    READ  = 1'b0;
    WRITE = 1'b0;
    tick();
  endtask

  logic busy_req;
  int   edges;

  initial begin
    vecs[0] = '{"wr_05",      1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{"rd_05",      1'b1, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{"wr_06",      1'b0, 1'b1, 6'h06, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[3] = '{"rd_06",      1'b1, 1'b0, 6'h06, 32'h0,        32'hCAFEF00D};
    vecs[4] = '{"rdwr_10",    1'b1, 1'b1, 6'h10, 32'hA5A5A5A5, 32'hCAFEF00D};
    vecs[5] = '{"rd_10",      1'b1, 1'b0, 6'h10, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{"wr_00",      1'b0, 1'b1, 6'h00, 32'h01020304, 32'hA5A5A5A5};
    vecs[7] = '{"rd_3e_zero", 1'b1, 1'b0, 6'h3E, 32'h0,        32'h00000000};
    vecs[8] = '{"rd_00",      1'b1, 1'b0, 6'h00, 32'h0,        32'h01020304};

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) tick();
    RESET = 1'b0;
    #1;
    check("reset_readdata", READDATA, 32'h0);
    check("reset_busywait", {31'b0, BUSYWAIT}, 32'h0);

    // Read of block 0 straight after reset.
    access(1'b1, 1'b0, 6'h00, 32'h0, busy_req, edges);
    check("rst_rd0_busy_req", {31'b0, busy_req}, 32'h1);
    check("rst_rd0_edges", edges, EXP_EDGES);
    check("rst_rd0_data", READDATA, 32'h0);

    // Table-driven accesses.
    for (int i = 0; i < NVEC; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             busy_req, edges);
      check({vecs[i].name, "_busy_req"}, {31'b0, busy_req}, 32'h1);
      check({vecs[i].name, "_edges"}, edges, EXP_EDGES);
      check({vecs[i].name, "_data"}, READDATA, vecs[i].exp_rdata);
    end

    // Byte order inside the array for block 0x05.
    check("byte20", {24'b0, dut.mem_q[20]}, 32'hEF);
    check("byte21", {24'b0, dut.mem_q[21]}, 32'hBE);
    check("byte22", {24'b0, dut.mem_q[22]}, 32'hAD);
    check("byte23", {24'b0, dut.mem_q[23]}, 32'hDE);

    // Inputs changed mid-access must not affect the write.
    WRITE = 1'b1; ADDRESS = 6'h3F; WRITEDATA = 32'h11223344;
    tick();                                   // E0 accepts
    ADDRESS = 6'h01; WRITEDATA = 32'hFFFFFFFF; READ = 1'b1;
    edges = 1;
    while (BUSYWAIT && edges < 30) begin
      tick();
      edges++;
    end
    check("midchg_edges", edges, EXP_EDGES);
    READ = 1'b0; WRITE = 1'b0;
    tick();
    access(1'b1, 1'b0, 6'h3F, 32'h0, busy_req, edges);
    check("midchg_rd_3f", READDATA, 32'h11223344);
    access(1'b1, 1'b0, 6'h01, 32'h0, busy_req, edges);
    check("midchg_rd_01", READDATA, 32'h00000000);

    // Handshake timing: READ held high across DONE and re-accepted at E7.
    READ = 1'b1; ADDRESS = 6'h05;
    for (int e = 0; e <= 4; e++) tick();      // E0..E4
    check("hs_e4_busy", {31'b0, BUSYWAIT}, 32'h1);
    check("hs_e4_old_data", READDATA, 32'h0);
    tick();                                   // E5
    check("hs_e5_busy_low", {31'b0, BUSYWAIT}, 32'h0);
    check("hs_e5_data", READDATA, 32'hDEADBEEF);
    ADDRESS = 6'h06;
    tick();                                   // E6: DONE ignores READ
    check("hs_e6_data_held", READDATA, 32'hDEADBEEF);
    check("hs_e6_busy_pending", {31'b0, BUSYWAIT}, 32'h1);
    for (int e = 7; e <= 11; e++) tick();     // E7 accepts .. E11
    check("hs_e11_busy", {31'b0, BUSYWAIT}, 32'h1);
    check("hs_e11_data_held", READDATA, 32'hDEADBEEF);
    tick();                                   // E12 completes
    check("hs_e12_busy_low", {31'b0, BUSYWAIT}, 32'h0);
    check("hs_e12_data", READDATA, 32'hCAFEF00D);
    READ = 1'b0;
    tick();

    // Reset during a write aborts it and clears everything.
    WRITE = 1'b1; ADDRESS = 6'h02; WRITEDATA = 32'h12345678;
    tick();                                   // E0
    tick();                                   // E1
    RESET = 1'b1;
    tick();                                   // E2 with reset
    RESET = 1'b0; WRITE = 1'b0;
    #1;
    check("rstmid_busy_low", {31'b0, BUSYWAIT}, 32'h0);
    check("rstmid_readdata", READDATA, 32'h0);
    repeat (LAT + 2) tick();
    check("rstmid_busy_quiet", {31'b0, BUSYWAIT}, 32'h0);
    access(1'b1, 1'b0, 6'h02, 32'h0, busy_req, edges);
    check("rstmid_edges", edges, EXP_EDGES);
    check("rstmid_rd_02", READDATA, 32'h0);
    access(1'b1, 1'b0, 6'h10, 32'h0, busy_req, edges);
    check("rstmid_rd_10_cleared", READDATA, 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
